// File: rtl/req_ack_tx_fifo.sv
// First-word-fall-through elastic buffer feeding the 4-phase req/ack transmitter.
// Tracks occupancy, raises almost_full, supports a synchronous flush and counts pops.
module req_ack_tx_fifo #(
    parameter  int unsigned DW       = 8,
    parameter  int unsigned DEPTH    = 8,
    parameter  int unsigned AF_LEVEL = 6,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic          clk_tx,
    input  logic          rst_b,
    input  logic          flush,
    input  logic          in_val,
    output logic          in_rdy,
    input  logic [DW-1:0] in_data,
    output logic          out_val,
    input  logic          out_rdy,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   count,
    output logic          almost_full,
    output logic [15:0]   xfer_cnt
);

    localparam logic [AW:0] AF_CMP = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   xfer_q, xfer_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Status is derived from registered pointers only, so in_rdy never sees out_rdy.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = in_val && !full;
    assign pop   = !empty && out_rdy;

    assign in_rdy      = !full;
    assign out_val     = !empty;
    assign out_data    = mem_q[rd_ptr_q[AW-1:0]];
    assign count       = count_q;
    assign almost_full = (count_q >= AF_CMP);
    assign xfer_cnt    = xfer_q;

    // Next-state: flush wins over any handshake in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        xfer_d   = xfer_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            xfer_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                xfer_d   = xfer_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + PTR_ONE;
                2'b01:   count_d = count_q - PTR_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_tx or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            xfer_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            xfer_q   <= xfer_d;
        end
    end

    // Storage is intentionally not reset; the head is only meaningful while out_val=1.
    always_ff @(posedge clk_tx) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_req_ack_tx_fifo.sv
// Self-checking bench for req_ack_tx_fifo: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, random traffic and a counter wrap.
module tb_req_ack_tx_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AF    = 3;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          clk_tx = 1'b0;
    logic          rst_b;
    logic          flush;
    logic          in_val;
    logic          in_rdy;
    logic [DW-1:0] in_data;
    logic          out_val;
    logic          out_rdy;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          almost_full;
    logic [15:0]   xfer_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    bit          chk_en = 1'b0;

    logic [DW-1:0] mq [$];
    int unsigned   mx = 0;

    req_ack_tx_fifo #(.DW(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk_tx      (clk_tx),
        .rst_b       (rst_b),
        .flush       (flush),
        .in_val      (in_val),
        .in_rdy      (in_rdy),
        .in_data     (in_data),
        .out_val     (out_val),
        .out_rdy     (out_rdy),
        .out_data    (out_data),
        .count       (count),
        .almost_full (almost_full),
        .xfer_cnt    (xfer_cnt)
    );

    always #5 clk_tx = ~clk_tx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a plain queue of words plus a pop counter modulo 2^16.
    always @(posedge clk_tx or negedge rst_b) begin : model
        bit pu;
        bit po;
        if (!rst_b) begin
            mq.delete();
            mx = 0;
        end else if (flush) begin
            mq.delete();
            mx = 0;
        end else begin
            pu = in_val && (mq.size() < DEPTH);
            po = out_rdy && (mq.size() > 0);
            if (po) begin
                void'(mq.pop_front());
                mx = (mx + 1) % 65536;
            end
            if (pu) mq.push_back(in_data);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_tx) begin
        if (chk_en) begin
            chk("out_val", 32'(out_val), 32'(mq.size() != 0));
            chk("in_rdy", 32'(in_rdy), 32'(mq.size() < DEPTH));
            chk("count", 32'(count), 32'(mq.size()));
            chk("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
            chk("xfer_cnt", 32'(xfer_cnt), 32'(mx));
            if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
        end
    end

    task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
        in_val  = iv;
        in_data = d;
        out_rdy = ordy;
        flush   = fl;
        @(posedge clk_tx);
        #1;
    endtask

    initial begin
        rst_b   = 1'b0;
        flush   = 1'b0;
        in_val  = 1'b0;
        in_data = '0;
        out_rdy = 1'b0;
        chk_en  = 1'b1;
        repeat (2) @(posedge clk_tx);
        #1;
        chk("rst_out_val", 32'(out_val), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        rst_b = 1'b1;
        cyc(0, 8'h00, 0, 0);

        // Fill to full with the transmitter stalled.
        cyc(1, 8'h11, 0, 0);
        chk("fill1_count", 32'(count), 32'd1);
        chk("fill1_af", 32'(almost_full), 32'd0);
        cyc(1, 8'h22, 0, 0);
        chk("fill2_count", 32'(count), 32'd2);
        cyc(1, 8'h33, 0, 0);
        chk("fill3_count", 32'(count), 32'd3);
        chk("fill3_af", 32'(almost_full), 32'd1);
        cyc(1, 8'h44, 0, 0);
        chk("fill4_count", 32'(count), 32'd4);
        chk("fill4_in_rdy", 32'(in_rdy), 32'd0);
        chk("fill4_head", 32'(out_data), 32'h11);
        cyc(1, 8'h55, 0, 0);
        chk("refused_count", 32'(count), 32'd4);
        chk("refused_head", 32'(out_data), 32'h11);

        // Pop while full: push is only possible the following cycle.
        cyc(1, 8'h55, 1, 0);
        chk("fullpop_count", 32'(count), 32'd3);
        chk("fullpop_in_rdy", 32'(in_rdy), 32'd1);
        chk("fullpop_head", 32'(out_data), 32'h22);
        cyc(1, 8'h55, 0, 0);
        chk("refill_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] exp_tab [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
            chk("drain_order", 32'(out_data), 32'(exp_tab[i]));
            cyc(0, 8'h00, 1, 0);
        end
        chk("drain_xfer", 32'(xfer_cnt), 32'd5);
        chk("drain_out_val", 32'(out_val), 32'd0);

        // Steady-state streaming at count 2.
        cyc(1, 8'hA0, 0, 0);
        cyc(1, 8'hA1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 8'(8'h40 + i), 1, 0);
            chk("stream_count", 32'(count), 32'd2);
        end
        chk("stream_xfer", 32'(xfer_cnt), 32'd15);
        chk("stream_head", 32'(out_data), 32'h48);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        chk("empty_out_val", 32'(out_val), 32'd0);

        // Push into empty: no bypass, out_rdy has no effect that cycle.
        cyc(1, 8'hA5, 1, 0);
        chk("nobypass_out_val", 32'(out_val), 32'd1);
        chk("nobypass_head", 32'(out_data), 32'hA5);
        chk("nobypass_xfer", 32'(xfer_cnt), 32'd17);

        // Flush at count 3 with both handshakes active.
        cyc(1, 8'hB1, 0, 0);
        cyc(1, 8'hB2, 0, 0);
        chk("preflush_count", 32'(count), 32'd3);
        cyc(1, 8'h77, 1, 1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_val", 32'(out_val), 32'd0);
        chk("flush_xfer", 32'(xfer_cnt), 32'd0);

        // Asynchronous reset mid-burst.
        cyc(1, 8'hC1, 0, 0);
        cyc(1, 8'hC2, 0, 0);
        in_val = 1'b0;
        #2;
        rst_b = 1'b0;
        #1;
        chk("areset_count", 32'(count), 32'd0);
        chk("areset_out_val", 32'(out_val), 32'd0);
        chk("areset_in_rdy", 32'(in_rdy), 32'd1);
        @(posedge clk_tx);
        #1;
        rst_b = 1'b1;
        cyc(1, 8'h3C, 0, 0);
        chk("postrst_head", 32'(out_data), 32'h3C);
        chk("postrst_count", 32'(count), 32'd1);

        // Randomised traffic, occasional flush.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 63) == 0));
        end

        // Long run to wrap the transfer counter.
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'h00, 0, 0);
        for (int i = 1; i <= 65535; i++) begin
            cyc(1, 8'(i), 1, 0);
        end
        chk("wrap_pre", 32'(xfer_cnt), 32'hFFFF);
        cyc(1, 8'h00, 1, 0);
        chk("wrap_post", 32'(xfer_cnt), 32'h0000);
        chk("wrap_count", 32'(count), 32'd1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/req_ack_tx_fifo.md
Name: req_ack_tx_fifo

Overview:
- Elastic buffer in the clk_tx domain, directly upstream of the 4-phase req/ack transmitter.
- Absorbs a bursty producer and presents words to the transmitter's val/rdy/din input.
- The transmitter accepts at most one word per full req/ack round trip, and that rate is slow and variable; this block decouples the producer from it.
- First-word-fall-through FIFO with an occupancy count, an almost-full flag, a synchronous flush and a wrapping transfer counter.

Parameters:
- DW, 8, data width; must equal the transmitter's DW.
- DEPTH, 8, number of entries; power of two, >= 2.
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
- AW, $clog2(DEPTH), pointer index width; derived, never overridden.

Ports:
- clk_tx  in  1  transmit-domain clock; all logic on its rising edge.
- rst_b  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all buffered words.
- in_val  in  1  producer word valid.
- in_rdy  out  1  FIFO can accept a word.
- in_data  in  DW  producer word.
- out_val  out  1  head word available; drives transmitter val.
- out_rdy  in  1  transmitter ready; driven from transmitter rdy.
- out_data  out  DW  head word; drives transmitter din.
- count  out  AW+1  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AF_LEVEL.
- xfer_cnt  out  16  words popped since reset/flush; wraps modulo 2^16.

Behaviour:
- Reset, clock clk_tx and rst_b (asynchronous, active-low) as already decided.
- While rst_b is low, immediately: wr_ptr=0, rd_ptr=0, count=0, xfer_cnt=0.
- During reset the outputs are out_val=0, in_rdy=1, almost_full=0.
- Storage array is not reset; out_data is don't-care while out_val=0.
- Pointers are AW+1 bits and wrap naturally. Full when the pointer MSBs differ and the low bits are equal; empty when the pointers are equal.
- Push: in_val & in_rdy at a rising edge writes mem[wr_ptr[AW-1:0]] and increments wr_ptr.
- Pop: out_val & out_rdy at a rising edge increments rd_ptr and xfer_cnt.
- in_rdy = !full, combinational from registered state only; never depends on out_rdy (no combinational path from out_rdy to in_rdy).
- out_val = !empty; out_data = mem[rd_ptr[AW-1:0]] (show-ahead).
- Latency: a word pushed at edge N is visible on out_val/out_data after edge N (one cycle). A pop at edge N presents the next word after edge N.
- count is registered: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- almost_full is combinational from count.
- Full, with out_rdy=1 in the same cycle: in_rdy stays 0 and no push occurs; a push is possible only on the following cycle.
- Empty: out_val=0, so no pop can occur. A push into an empty FIFO is not bypassed to the output in the same cycle.
- Simultaneous push and pop when neither full nor empty: both happen; count unchanged.
- flush=1 at an edge takes priority over push and pop:
  - next state is wr_ptr=rd_ptr=0, count=0, xfer_cnt=0;
  - the in_val/out_rdy handshakes in that cycle are discarded; the producer must treat the word as not accepted (in_rdy is still observed high, so the flush is owned by the producer's controller);
  - out_val is 0 the cycle after the flush.
- Flush while the transmitter has a req in flight is legal. The transmitter already holds its own copy of the word; this block does not interact with req/ack.
- Data stability: while out_val=1 and no pop occurs, out_data must not change, including when a push is happening. This is required for the transmitter, which captures on val&rdy.
- Reset mid-operation: all state is lost immediately and asynchronously; on deassertion the block behaves as freshly reset.
- xfer_cnt wraps 0xFFFF -> 0x0000 on pop, with no flag.

Test Plan:
- DEPTH=4, AF_LEVEL=3, out_rdy=0; push 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4. almost_full rises when count=3; in_rdy=0 after the 4th push. out_data=0x11 throughout; a 5th push attempt is refused.
- From that full state, hold in_val=1 with 0x55 and pulse out_rdy one cycle -> pop 0x11 and count=3. The next cycle in_rdy=1 and 0x55 is accepted; drain order is 0x22,0x33,0x44,0x55; xfer_cnt=5.
- Count 2, in_val=1 and out_rdy=1 for 10 cycles with incrementing data -> count stays 2 every cycle. Output order equals input order; xfer_cnt advances by 10.
- Empty FIFO, push 0xA5 at edge N -> out_val=0 before edge N and out_val=1 with out_data=0xA5 after edge N. out_rdy=1 in cycle N has no effect.
- Count 3, assert flush with in_val=1 and out_rdy=1 in the same cycle -> next cycle count=0, out_val=0, xfer_cnt=0. No word is popped and the in_data word is not stored.
- Mid-burst (count 2), pull rst_b low asynchronously between edges -> count=0 and out_val=0 immediately. After release, a push of 0x3C emerges first; xfer_cnt wraps from 0xFFFF to 0 after 65536 pops in a long run.
